// File: rtl/result_uart_tx_pkg.sv
// Shared constants for the result UART transmitter: frame header, FSM encoding
// and UART character framing.
package result_uart_tx_pkg;

    typedef logic [2:0] state_t;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;
    localparam int         UART_BITS    = 10;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_RD   = 3'd1;
    localparam state_t ST_CAP  = 3'd2;
    localparam state_t ST_SEND = 3'd3;
    localparam state_t ST_CHK  = 3'd4;

    // Line image of one 8N1 character, shifted out LSB first: start, data, stop.
    function automatic logic [UART_BITS-1:0] uart_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/result_uart_tx_uart_byte_tx.sv
// 8N1 byte serializer: each bit is held CLK_FREQ/BAUD clocks and done pulses on
// the final clock of the stop bit so the caller can chain the next byte.
module uart_byte_tx
    import result_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       done_o,
    output logic       tx_o
);

    localparam int BIT_CLKS = CLK_FREQ / BAUD;
    localparam int CW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

    logic                 active_q, active_d;
    logic [CW-1:0]        baud_cnt_q, baud_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [UART_BITS-1:0] shift_q, shift_d;
    logic                 bit_end;

    assign bit_end = (baud_cnt_q == CW'(BIT_CLKS - 1));
    assign done_o  = active_q && bit_end && (bit_cnt_q == 4'(UART_BITS - 1));
    // Gating with active_q lets reset force the line high without waiting for a clock.
    assign tx_o    = active_q ? shift_q[0] : 1'b1;

    always_comb begin
        active_d   = active_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        if (!active_q) begin
            if (start_i) begin
                active_d   = 1'b1;
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                shift_d    = uart_frame(data_i);
            end
        end else if (bit_end) begin
            baud_cnt_d = '0;
            if (bit_cnt_q == 4'(UART_BITS - 1)) begin
                active_d  = 1'b0;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                shift_d   = {1'b1, shift_q[UART_BITS-1:1]};
            end
        end else begin
            baud_cnt_d = baud_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q   <= 1'b0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '1;
        end else begin
            active_q   <= active_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

endmodule

// File: rtl/result_uart_tx.sv
// Drains BATCH calibrated results from an external FIFO into one UART frame:
// header 0xA5, each word MSB first, then the 8-bit sum of the payload bytes.
module result_uart_tx
    import result_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int BATCH    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] result_i,
    input  logic [8:0]  usedw_i,
    output logic        read_data_o,
    output logic        tx_o,
    output logic        busy_o,
    output logic [15:0] frame_cnt_o
);

    state_t      state_q, state_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [7:0]  chk_q, chk_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        busy_q, busy_d;
    logic        start_q, start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_active_q, tx_active_d;
    logic        chk_sent_q, chk_sent_d;
    logic        ser_done;
    logic        ser_free;

    // The serializer counts as free on its done cycle so bytes chain with a one-clock gap.
    assign ser_free    = !tx_active_q || ser_done;
    assign read_data_o = (state_q == ST_RD);
    assign busy_o      = busy_q;
    assign frame_cnt_o = frame_cnt_q;

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        chk_d       = chk_q;
        frame_cnt_d = frame_cnt_q;
        busy_d      = busy_q;
        start_d     = 1'b0;
        tx_data_d   = tx_data_q;
        tx_active_d = ser_done ? 1'b0 : tx_active_q;
        chk_sent_d  = chk_sent_q;
        case (state_q)
            ST_IDLE: begin
                if (usedw_i >= 9'(BATCH)) begin
                    busy_d      = 1'b1;
                    chk_d       = '0;
                    word_cnt_d  = '0;
                    start_d     = 1'b1;
                    tx_data_d   = FRAME_HEADER;
                    tx_active_d = 1'b1;
                    state_d     = ST_RD;
                end
            end
            ST_RD: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                shift_d    = result_i;
                byte_cnt_d = '0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (ser_free) begin
                    start_d     = 1'b1;
                    tx_data_d   = shift_q[31:24];
                    shift_d     = {shift_q[23:0], 8'h00};
                    chk_d       = chk_q + shift_q[31:24];
                    tx_active_d = 1'b1;
                    byte_cnt_d  = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        word_cnt_d = word_cnt_q + 8'd1;
                        state_d    = (word_cnt_q == 8'(BATCH - 1)) ? ST_CHK : ST_RD;
                    end
                end
            end
            ST_CHK: begin
                if (!chk_sent_q && ser_free) begin
                    start_d     = 1'b1;
                    tx_data_d   = chk_q;
                    tx_active_d = 1'b1;
                    chk_sent_d  = 1'b1;
                end else if (chk_sent_q && ser_done) begin
                    chk_sent_d  = 1'b0;
                    busy_d      = 1'b0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            word_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            chk_q       <= '0;
            frame_cnt_q <= '0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            tx_data_q   <= '0;
            tx_active_q <= 1'b0;
            chk_sent_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            chk_q       <= chk_d;
            frame_cnt_q <= frame_cnt_d;
            busy_q      <= busy_d;
            start_q     <= start_d;
            tx_data_q   <= tx_data_d;
            tx_active_q <= tx_active_d;
            chk_sent_q  <= chk_sent_d;
        end
    end

    uart_byte_tx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) u_byte_tx (
        .clk    (clk),
        .rst    (rst),
        .start_i(start_q),
        .data_i (tx_data_q),
        .done_o (ser_done),
        .tx_o   (tx_o)
    );

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: a FIFO model feeds words, a line decoder rebuilds bytes,
// and each scenario compares the decoded frame with its own expected byte list.
module tb_result_uart_tx;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD      = 250_000;
    localparam int BATCH     = 8;
    localparam int BYTE_CLKS = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] result = '0;
    logic [8:0]  usedw;
    logic        readData;
    logic        tx;
    logic        busy;
    logic [15:0] frameCnt;

    int nChecks = 0;
    int nFail   = 0;

    logic [31:0] fifoMem [64];
    int   fillBase    = 0;
    int   rdTotal     = 0;
    int   rdUnderflow = 0;
    int   rdDouble    = 0;
    logic rdPrev      = 1'b0;

    logic [7:0] rxBytes [$];
    int         rxStart [$];
    logic [7:0] expBytes [$];
    logic [7:0] rxShift    = '0;
    logic       rxActive   = 1'b0;
    int         rxCnt      = 0;
    int         rxStartCyc = 0;
    int         cyc        = 0;
    int         framingErr = 0;

    always #5 clk = ~clk;

    assign usedw = 9'(fillBase - rdTotal);

    result_uart_tx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .BATCH   (BATCH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .result_i   (result),
        .usedw_i    (usedw),
        .read_data_o(readData),
        .tx_o       (tx),
        .busy_o     (busy),
        .frame_cnt_o(frameCnt)
    );

    // Show-ahead-free FIFO: data appears the cycle after a read request.
    always @(posedge clk) begin
        if (readData) begin
            result  <= fifoMem[rdTotal % 64];
            rdTotal <= rdTotal + 1;
            if (usedw == 9'd0) rdUnderflow <= rdUnderflow + 1;
            if (rdPrev) rdDouble <= rdDouble + 1;
        end
        rdPrev <= readData;
    end

    // Line decoder sampling mid-bit: 4 clocks per bit, counted on falling edges.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            rxActive <= 1'b0;
        end else if (!rxActive) begin
            if (tx === 1'b0) begin
                rxActive   <= 1'b1;
                rxCnt      <= 1;
                rxStartCyc <= cyc;
            end
        end else begin
            rxCnt <= rxCnt + 1;
            if (rxCnt >= 6 && rxCnt <= 34 && rxCnt % 4 == 2) rxShift[3'((rxCnt - 6) / 4)] <= tx;
            if (rxCnt == 38) begin
                if (tx !== 1'b1) framingErr <= framingErr + 1;
                rxBytes.push_back(rxShift);
                rxStart.push_back(rxStartCyc);
                rxActive <= 1'b0;
            end
        end
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached, frames seen %0d bytes", rxBytes.size());
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic fifoLoad(input int n, input logic [31:0] first, input logic [31:0] step);
        fillBase = rdTotal;
        for (int i = 0; i < n; i++) fifoMem[(rdTotal + i) % 64] = first + step * 32'(i);
        fillBase = rdTotal + n;
    endtask

    task automatic expectFrame(input logic [31:0] first, input logic [31:0] step);
        logic [7:0]  sum;
        logic [31:0] w;
        sum = 8'h00;
        expBytes.push_back(8'hA5);
        for (int i = 0; i < BATCH; i++) begin
            w = first + step * 32'(i);
            for (int b = 3; b >= 0; b--) begin
                expBytes.push_back(w[b*8 +: 8]);
                sum = sum + w[b*8 +: 8];
            end
        end
        expBytes.push_back(sum);
    endtask

    task automatic waitFrame(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        while ((rxBytes.size() < target || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (rxBytes.size() >= target) && !busy;
        repeat (60) @(negedge clk);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        nChecks++; if (tx !== 1'b1) begin nFail++; $display("[TB] FAIL reset_tx: got %b, required 1", tx); end
        nChecks++; if (readData !== 1'b0) begin nFail++; $display("[TB] FAIL reset_read: got %b, required 0", readData); end
        nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
        nChecks++; if (frameCnt !== 16'h0000) begin nFail++; $display("[TB] FAIL reset_frame_cnt: got %h, required 0000", frameCnt); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL post_reset_idle: busy %b, required 0", busy); end
    endtask

    task automatic test_below_threshold();
        int txLow, busyHigh, rd0;
        txLow = 0; busyHigh = 0; rd0 = rdTotal;
        fifoLoad(7, 32'h1, 32'h1);
        repeat (2000) begin
            @(negedge clk);
            if (tx !== 1'b1) txLow++;
            if (busy !== 1'b0) busyHigh++;
        end
        nChecks++; if (txLow != 0) begin nFail++; $display("[TB] FAIL below_tx: %0d low clocks, required 0", txLow); end
        nChecks++; if (busyHigh != 0) begin nFail++; $display("[TB] FAIL below_busy: %0d busy clocks, required 0", busyHigh); end
        nChecks++; if (rdTotal != rd0) begin nFail++; $display("[TB] FAIL below_reads: %0d reads, required 0", rdTotal - rd0); end
    endtask

    task automatic test_nominal();
        int base, rd0, gap, minGap, maxGap, span;
        bit ok;
        logic [7:0] got;
        base = rxBytes.size(); rd0 = rdTotal;
        expBytes.delete();
        expectFrame(32'h1, 32'h1);
        fifoLoad(8, 32'h1, 32'h1);
        waitFrame(base + 34, 4000, ok);
        nChecks++; if (!ok) begin nFail++; $display("[TB] FAIL nominal_done: %0d bytes seen busy=%b, required 34 and idle", rxBytes.size() - base, busy); end
        nChecks++; if (rxBytes.size() - base != 34) begin nFail++; $display("[TB] FAIL nominal_len: %0d bytes, required 34", rxBytes.size() - base); end
        for (int i = 0; i < expBytes.size() && base + i < rxBytes.size(); i++) begin
            nChecks++;
            if (rxBytes[base + i] !== expBytes[i]) begin nFail++; $display("[TB] FAIL nominal_byte%0d: got %h, required %h", i, rxBytes[base + i], expBytes[i]); end
        end
        got = (rxBytes.size() > base + 33) ? rxBytes[base + 33] : 8'hxx;
        nChecks++; if (got !== 8'h24) begin nFail++; $display("[TB] FAIL nominal_checksum: got %h, required 24", got); end
        nChecks++; if (rdTotal - rd0 != 8) begin nFail++; $display("[TB] FAIL nominal_reads: %0d pulses, required 8", rdTotal - rd0); end
        nChecks++; if (frameCnt !== 16'd1) begin nFail++; $display("[TB] FAIL nominal_frame_cnt: got %0d, required 1", frameCnt); end
        nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL nominal_busy: got %b, required 0", busy); end
        nChecks++; if (framingErr != 0) begin nFail++; $display("[TB] FAIL nominal_stop_bits: %0d bad stop bits, required 0", framingErr); end
        if (rxStart.size() >= base + 34) begin
            minGap = 1000; maxGap = -1000;
            for (int i = 1; i < 34; i++) begin
                gap = rxStart[base + i] - rxStart[base + i - 1] - BYTE_CLKS;
                if (gap < minGap) minGap = gap;
                if (gap > maxGap) maxGap = gap;
            end
            span = rxStart[base + 33] + BYTE_CLKS - rxStart[base];
            nChecks++; if (minGap < 0 || maxGap > 2) begin nFail++; $display("[TB] FAIL nominal_byte_gap: gaps %0d..%0d clocks, required 0..2", minGap, maxGap); end
            nChecks++; if (span < 1360 || span > 1360 + 66) begin nFail++; $display("[TB] FAIL nominal_frame_span: %0d clocks, required 1360..1426", span); end
        end
    endtask

    task automatic test_checksum_wrap();
        int base;
        bit ok;
        logic [7:0] got;
        base = rxBytes.size();
        expBytes.delete();
        expectFrame(32'hFFFF_FFFF, 32'h0);
        fifoLoad(8, 32'hFFFF_FFFF, 32'h0);
        waitFrame(base + 34, 4000, ok);
        nChecks++; if (!ok) begin nFail++; $display("[TB] FAIL wrap_done: %0d bytes seen busy=%b, required 34 and idle", rxBytes.size() - base, busy); end
        nChecks++; if (rxBytes.size() - base != 34) begin nFail++; $display("[TB] FAIL wrap_len: %0d bytes, required 34", rxBytes.size() - base); end
        for (int i = 0; i < expBytes.size() && base + i < rxBytes.size(); i++) begin
            nChecks++;
            if (rxBytes[base + i] !== expBytes[i]) begin nFail++; $display("[TB] FAIL wrap_byte%0d: got %h, required %h", i, rxBytes[base + i], expBytes[i]); end
        end
        got = (rxBytes.size() > base + 33) ? rxBytes[base + 33] : 8'hxx;
        nChecks++; if (got !== 8'hE0) begin nFail++; $display("[TB] FAIL wrap_checksum: got %h, required E0", got); end
        nChecks++; if (frameCnt !== 16'd2) begin nFail++; $display("[TB] FAIL wrap_frame_cnt: got %0d, required 2", frameCnt); end
    endtask

    task automatic test_mid_frame_reset();
        int base, n, txLow, busyHigh;
        bit ok;
        logic [7:0] got;
        base = rxBytes.size();
        fifoLoad(8, 32'h0, 32'h0);
        n = 0;
        while (rxBytes.size() < base + 3 && n < 2000) begin @(negedge clk); n++; end
        nChecks++; if (rxBytes.size() < base + 3) begin nFail++; $display("[TB] FAIL midrst_reach: %0d bytes, required 3 before reset", rxBytes.size() - base); end
        repeat (12) @(posedge clk);
        #1;
        nChecks++; if (tx !== 1'b0) begin nFail++; $display("[TB] FAIL midrst_pre_low: tx %b, required 0 inside payload byte 3", tx); end
        rst = 1'b1;
        #1;
        nChecks++; if (tx !== 1'b1) begin nFail++; $display("[TB] FAIL midrst_async_tx: got %b, required 1", tx); end
        repeat (3) @(negedge clk);
        nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL midrst_busy: got %b, required 0", busy); end
        nChecks++; if (frameCnt !== 16'd0) begin nFail++; $display("[TB] FAIL midrst_frame_cnt: got %0d, required 0", frameCnt); end
        rst = 1'b0;
        fifoLoad(7, 32'h0, 32'h0);
        txLow = 0; busyHigh = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1) txLow++;
            if (busy !== 1'b0) busyHigh++;
        end
        nChecks++; if (txLow != 0 || busyHigh != 0) begin nFail++; $display("[TB] FAIL midrst_hold: %0d low / %0d busy clocks, required 0 / 0", txLow, busyHigh); end
        base = rxBytes.size();
        expBytes.delete();
        expectFrame(32'h0102_0304, 32'h0101_0101);
        fifoLoad(8, 32'h0102_0304, 32'h0101_0101);
        waitFrame(base + 34, 4000, ok);
        got = (rxBytes.size() > base) ? rxBytes[base] : 8'hxx;
        nChecks++; if (got !== 8'hA5) begin nFail++; $display("[TB] FAIL midrst_header: got %h, required A5", got); end
        nChecks++; if (rxBytes.size() - base != 34) begin nFail++; $display("[TB] FAIL midrst_len: %0d bytes, required 34", rxBytes.size() - base); end
        for (int i = 1; i < expBytes.size() && base + i < rxBytes.size(); i++) begin
            nChecks++;
            if (rxBytes[base + i] !== expBytes[i]) begin nFail++; $display("[TB] FAIL midrst_byte%0d: got %h, required %h", i, rxBytes[base + i], expBytes[i]); end
        end
        nChecks++; if (frameCnt !== 16'd1) begin nFail++; $display("[TB] FAIL midrst_frame_cnt_after: got %0d, required 1", frameCnt); end
    endtask

    task automatic test_back_to_back();
        int base, rd0, gap;
        bit ok;
        logic [7:0] got;
        pulseReset();
        base = rxBytes.size(); rd0 = rdTotal;
        expBytes.delete();
        expectFrame(32'h0000_0010, 32'h0000_0003);
        expectFrame(32'h0000_0028, 32'h0000_0003);
        fifoLoad(16, 32'h0000_0010, 32'h0000_0003);
        waitFrame(base + 68, 7000, ok);
        nChecks++; if (!ok) begin nFail++; $display("[TB] FAIL b2b_done: %0d bytes seen busy=%b, required 68 and idle", rxBytes.size() - base, busy); end
        nChecks++; if (rxBytes.size() - base != 68) begin nFail++; $display("[TB] FAIL b2b_len: %0d bytes, required 68", rxBytes.size() - base); end
        for (int i = 0; i < expBytes.size() && base + i < rxBytes.size(); i++) begin
            nChecks++;
            if (rxBytes[base + i] !== expBytes[i]) begin nFail++; $display("[TB] FAIL b2b_byte%0d: got %h, required %h", i, rxBytes[base + i], expBytes[i]); end
        end
        got = (rxBytes.size() > base + 34) ? rxBytes[base + 34] : 8'hxx;
        nChecks++; if (got !== 8'hA5) begin nFail++; $display("[TB] FAIL b2b_second_header: got %h, required A5", got); end
        gap = (rxStart.size() > base + 34) ? rxStart[base + 34] - rxStart[base + 33] - BYTE_CLKS : -99;
        nChecks++; if (gap < 0 || gap > 2) begin nFail++; $display("[TB] FAIL b2b_frame_gap: %0d clocks, required 0..2", gap); end
        nChecks++; if (rdTotal - rd0 != 16) begin nFail++; $display("[TB] FAIL b2b_reads: %0d pulses, required 16", rdTotal - rd0); end
        nChecks++; if (frameCnt !== 16'd2) begin nFail++; $display("[TB] FAIL b2b_frame_cnt: got %0d, required 2", frameCnt); end
    endtask

    task automatic test_read_protocol();
        nChecks++; if (rdUnderflow != 0) begin nFail++; $display("[TB] FAIL read_empty: %0d reads at usedw 0, required 0", rdUnderflow); end
        nChecks++; if (rdDouble != 0) begin nFail++; $display("[TB] FAIL read_pulse_width: %0d multi-cycle pulses, required 0", rdDouble); end
    endtask

    initial begin
        test_reset();
        test_below_threshold();
        test_nominal();
        test_checksum_wrap();
        test_mid_frame_reset();
        test_back_to_back();
        test_read_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
